// File: rtl/instr_encoder.sv
// instr_encoder: hardware program loader. Encodes structured instruction requests into 32-bit
// instruction words and writes them to consecutive instruction-memory addresses starting at a
// programmable base address.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, finish         one-cycle control pulses (start wins when both are high)
//   base_addr             start word address, sampled on start
//   in_valid / in_ready   request handshake
//   in_kind .. in_imm     request fields (kind, cond, cmd, s, rd, rn, rm, imm)
//   imem_we/addr/wdata    registered instruction-memory write port
//   count, full, err      words written since start, count==DEPTH, sticky error flag
//   state_o               0 idle, 1 load, 2 full
//   checksum              XOR of all words written since start (INSTR_ENCODER_CHECKSUM_EN only)
//
// Optional feature macro: INSTR_ENCODER_CHECKSUM_EN adds the checksum output.
module instr_encoder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_cmd,
  input  logic              in_s,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rm,
  input  logic [23:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [1:0]        state_o
`ifdef INSTR_ENCODER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [2:0] KindDpReg = 3'd0;
  localparam logic [2:0] KindDpImm = 3'd1;
  localparam logic [2:0] KindLdr   = 3'd2;
  localparam logic [2:0] KindStr   = 3'd3;
  localparam logic [2:0] KindB     = 3'd4;

  localparam logic [ADDR_W:0]   DepthC   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CountOne = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StFull = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                full_q, full_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
`ifdef INSTR_ENCODER_CHECKSUM_EN
  logic [31:0]         csum_q, csum_d;
`endif

  logic [31:0] enc_word;
  logic        enc_bad;
  logic        accept;

  // Instruction word encoder; enc_bad flags illegal kinds and immediates that do not fit.
  always_comb begin
    enc_word = '0;
    enc_bad  = 1'b0;
    unique case (in_kind)
      KindDpReg: begin
        enc_word = {in_cond, 2'b00, 1'b0, in_cmd, in_s, in_rn, in_rd,
                    in_imm[4:0], 2'b00, 1'b0, in_rm};
        enc_bad  = |in_imm[23:5];
      end
      KindDpImm: begin
        enc_word = {in_cond, 2'b00, 1'b1, in_cmd, in_s, in_rn, in_rd, 4'b0000, in_imm[7:0]};
        enc_bad  = |in_imm[23:8];
      end
      KindLdr, KindStr: begin
        enc_word = {in_cond, 2'b01, 5'b01100, (in_kind == KindLdr), in_rn, in_rd,
                    in_imm[11:0]};
        enc_bad  = |in_imm[23:12];
      end
      KindB: begin
        enc_word = {in_cond, 2'b10, 2'b10, in_imm};
        enc_bad  = 1'b0;
      end
      default: begin
        enc_word = '0;
        enc_bad  = 1'b1;
      end
    endcase
  end

  // Control pulses block acceptance so they never race a request in the same cycle.
  assign in_ready = (state_q == StLoad) & ~full_q & ~start & ~finish;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    full_d  = full_q;
    err_d   = err_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef INSTR_ENCODER_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    if (start) begin
      // A write registered last cycle is already on the port and completes untouched.
      state_d = StLoad;
      addr_d  = base_addr;
      count_d = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else if (finish) begin
      state_d = StIdle;
    end else if (accept) begin
      if (enc_bad) begin
        err_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = enc_word;
        addr_d  = addr_q + AddrOne;
        count_d = count_q + CountOne;
        full_d  = (count_d == DepthC);
        if (full_d) begin
          state_d = StFull;
        end
`ifdef INSTR_ENCODER_CHECKSUM_EN
        csum_d  = csum_q ^ enc_word;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef INSTR_ENCODER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign full       = full_q;
  assign err        = err_q;
  assign state_o    = state_q;
`ifdef INSTR_ENCODER_CHECKSUM_EN
  assign checksum   = csum_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (ADDR_W=8, DEPTH=4). Expected writes are pushed to a
// scoreboard queue when a request is accepted and compared when the DUT strobes imem_we.
module tb_instr_encoder;

  localparam int unsigned AW = 8;
  localparam int unsigned DP = 4;

  logic          clk = 1'b0;
  logic          reset, start, finish;
  logic [AW-1:0] base_addr;
  logic          in_valid, in_ready;
  logic [2:0]    in_kind;
  logic [3:0]    in_cond, in_cmd, in_rd, in_rn, in_rm;
  logic          in_s;
  logic [23:0]   in_imm;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          full, err;
  logic [1:0]    state_o;
`ifdef INSTR_ENCODER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  instr_encoder #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .finish     (finish),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_cond    (in_cond),
    .in_cmd     (in_cmd),
    .in_s       (in_s),
    .in_rd      (in_rd),
    .in_rn      (in_rn),
    .in_rm      (in_rm),
    .in_imm     (in_imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .full       (full),
    .err        (err),
    .state_o    (state_o)
`ifdef INSTR_ENCODER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [31:0]   csum;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_pass  = 0;
  int            n_total = 0;
  logic [AW-1:0] exp_addr;
  logic [AW:0]   exp_count;
  logic [31:0]   exp_csum;

  // Reference encoder built field by field.
  function automatic logic [31:0] model_word(input logic [2:0] k, input logic [3:0] cond,
                                             input logic [3:0] cmd, input logic s,
                                             input logic [3:0] rd, input logic [3:0] rn,
                                             input logic [3:0] rm, input logic [23:0] imm);
    logic [31:0] w;
    w = '0;
    w[31:28] = cond;
    w[15:12] = rd;
    case (k)
      3'd0: begin
        w[24:21] = cmd; w[20] = s; w[19:16] = rn; w[11:7] = imm[4:0]; w[3:0] = rm;
      end
      3'd1: begin
        w[25] = 1'b1; w[24:21] = cmd; w[20] = s; w[19:16] = rn; w[7:0] = imm[7:0];
      end
      3'd2, 3'd3: begin
        w[26] = 1'b1; w[24] = 1'b1; w[23] = 1'b1; w[20] = (k == 3'd2);
        w[19:16] = rn; w[11:0] = imm[11:0];
      end
      3'd4: begin
        w[27] = 1'b1; w[25] = 1'b1; w[23:0] = imm;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic bit model_bad(input logic [2:0] k, input logic [23:0] imm);
    case (k)
      3'd0:       return imm >= 24'd32;
      3'd1:       return imm >= 24'd256;
      3'd2, 3'd3: return imm >= 24'd4096;
      3'd4:       return 1'b0;
      default:    return 1'b1;
    endcase
  endfunction

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (imem_we) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_write addr=%h data=%h required no write", imem_addr, imem_wdata);
      end else begin
        mon_e = sb.pop_front();
        if (imem_addr !== mon_e.addr || imem_wdata !== mon_e.data)
          $display("FAIL write addr=%h data=%h required addr=%h data=%h",
                   imem_addr, imem_wdata, mon_e.addr, mon_e.data);
        else n_pass++;
`ifdef INSTR_ENCODER_CHECKSUM_EN
        n_total++;
        if (checksum !== mon_e.csum)
          $display("FAIL checksum got=%h required=%h", checksum, mon_e.csum);
        else n_pass++;
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] k, input logic [3:0] cond, input logic [3:0] cmd,
                      input logic s, input logic [3:0] rd, input logic [3:0] rn,
                      input logic [3:0] rm, input logic [23:0] imm, output int waited);
    exp_t e;
    bit   done;
    in_valid = 1'b1; in_kind = k; in_cond = cond; in_cmd = cmd; in_s = s;
    in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm;
    waited = 0;
    done = 1'b0;
    while (!done && waited < 20) begin
      @(negedge clk);
      if (in_ready) begin
        if (!model_bad(k, imm)) begin
          e.data    = model_word(k, cond, cmd, s, rd, rn, rm, imm);
          e.addr    = exp_addr;
          exp_csum  = exp_csum ^ e.data;
          e.csum    = exp_csum;
          sb.push_back(e);
          exp_addr  = exp_addr + 1'b1;
          exp_count = exp_count + 1'b1;
        end
        done = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_total++;
      $display("FAIL handshake_timeout kind=%0d in_ready stayed 0 required 1", k);
    end
  endtask

  task automatic do_start(input logic [AW-1:0] base);
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = base; exp_count = '0; exp_csum = '0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 0; finish = 0; base_addr = '0; in_valid = 1'b1;
    in_kind = 3'd4; in_cond = 4'hE; in_cmd = 0; in_s = 0; in_rd = 0; in_rn = 0; in_rm = 0;
    in_imm = 0; exp_addr = 0; exp_count = 0; exp_csum = 0;
    idle_cycles(3);
    @(negedge clk);
    n_total++; if (state_o !== 2'd0) $display("FAIL rst_state got=%0d required=0", state_o); else n_pass++;
    n_total++; if (imem_we !== 1'b0) $display("FAIL rst_we got=%b required=0", imem_we); else n_pass++;
    n_total++; if (imem_addr !== '0) $display("FAIL rst_addr got=%h required=0", imem_addr); else n_pass++;
    n_total++; if (imem_wdata !== '0) $display("FAIL rst_wdata got=%h required=0", imem_wdata); else n_pass++;
    n_total++; if (count !== '0) $display("FAIL rst_count got=%0d required=0", count); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL rst_full got=%b required=0", full); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL rst_err got=%b required=0", err); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL rst_ready got=%b required=0", in_ready); else n_pass++;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(1);
  endtask

  task automatic test_dp_imm;
    int w;
    do_start(8'h10);
    send(3'd1, 4'hE, 4'b0100, 1'b0, 4'd2, 4'd1, 4'd0, 24'd5, w);
    @(negedge clk);
    n_total++; if (imem_wdata !== 32'hE2812005) $display("FAIL dp_imm_word got=%h required=e2812005", imem_wdata); else n_pass++;
    n_total++; if (count !== 9'd1) $display("FAIL dp_imm_count got=%0d required=1", count); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int w0, w1;
    do_start(8'h10);
    send(3'd2, 4'hE, 4'h0, 1'b0, 4'd4, 4'd3, 4'd0, 24'd8, w0);
    send(3'd4, 4'hE, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 24'hFFFFFE, w1);
    n_total++; if (w0 + w1 != 0) $display("FAIL b2b_stall waited=%0d required=0", w0 + w1); else n_pass++;
    idle_cycles(2);
    @(negedge clk);
    n_total++; if (count !== exp_count) $display("FAIL b2b_count got=%0d required=%0d", count, exp_count); else n_pass++;
    n_total++; if (sb.size() != 0) $display("FAIL b2b_pending got=%0d required=0", sb.size()); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap_full;
    int w;
    do_start(8'hFE);
    send(3'd0, 4'h1, 4'hD, 1'b1, 4'd5, 4'd6, 4'd7, 24'd3, w);
    send(3'd1, 4'h0, 4'h2, 1'b1, 4'd8, 4'd9, 4'd0, 24'hA5, w);
    send(3'd3, 4'hA, 4'h0, 1'b0, 4'd1, 4'd2, 4'd0, 24'h7FF, w);
    send(3'd4, 4'h3, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 24'h000123, w);
    in_valid = 1'b1; in_kind = 3'd4; in_imm = 24'h5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_total++; if (in_ready !== 1'b0) $display("FAIL full_ready cyc=%0d got=%b required=0", i, in_ready); else n_pass++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_total++; if (full !== 1'b1) $display("FAIL full_flag got=%b required=1", full); else n_pass++;
    n_total++; if (state_o !== 2'd2) $display("FAIL full_state got=%0d required=2", state_o); else n_pass++;
    n_total++; if (count !== 9'd4) $display("FAIL full_count got=%0d required=4", count); else n_pass++;
    n_total++; if (sb.size() != 0) $display("FAIL wrap_pending got=%0d required=0", sb.size()); else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
    @(negedge clk);
    n_total++; if (state_o !== 2'd0) $display("FAIL full_finish_state got=%0d required=0", state_o); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_errors;
    int w;
    do_start(8'h20);
    send(3'd1, 4'hE, 4'h4, 1'b0, 4'd2, 4'd1, 4'd0, 24'h100, w);
    send(3'd6, 4'hE, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 24'h0, w);
    send(3'd0, 4'hE, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 24'h20, w);
    send(3'd2, 4'hE, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 24'h1000, w);
    idle_cycles(1);
    @(negedge clk);
    n_total++; if (err !== 1'b1) $display("FAIL err_set got=%b required=1", err); else n_pass++;
    n_total++; if (count !== 9'd0) $display("FAIL err_count got=%0d required=0", count); else n_pass++;
    @(posedge clk); #1;
    send(3'd0, 4'h7, 4'hC, 1'b1, 4'd3, 4'd4, 4'd9, 24'h1F, w);
    idle_cycles(1);
    @(negedge clk);
    n_total++; if (count !== 9'd1) $display("FAIL err_legal_count got=%0d required=1", count); else n_pass++;
    n_total++; if (err !== 1'b1) $display("FAIL err_sticky got=%b required=1", err); else n_pass++;
    @(posedge clk); #1;
    do_start(8'h60);
    @(negedge clk);
    n_total++; if (err !== 1'b0) $display("FAIL err_clear got=%b required=0", err); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_start_inflight;
    int w;
    do_start(8'h30);
    send(3'd1, 4'hE, 4'h4, 1'b0, 4'd2, 4'd1, 4'd0, 24'h42, w);
    do_start(8'h40);
    send(3'd2, 4'hE, 4'h0, 1'b0, 4'd4, 4'd3, 4'd0, 24'd8, w);
    @(negedge clk);
    n_total++; if (count !== 9'd1) $display("FAIL restart_count got=%0d required=1", count); else n_pass++;
    @(posedge clk); #1;
    idle_cycles(1);
  endtask

  task automatic test_finish_inflight;
    int w;
    do_start(8'h50);
    send(3'd3, 4'h2, 4'h0, 1'b0, 4'd6, 4'd7, 4'd0, 24'h123, w);
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
    @(negedge clk);
    n_total++; if (state_o !== 2'd0) $display("FAIL finish_state got=%0d required=0", state_o); else n_pass++;
    n_total++; if (count !== 9'd1) $display("FAIL finish_count got=%0d required=1", count); else n_pass++;
    @(posedge clk); #1;
    start = 1'b1; finish = 1'b1; base_addr = 8'h70;
    @(posedge clk); #1;
    start = 1'b0; finish = 1'b0;
    exp_addr = 8'h70; exp_count = '0; exp_csum = '0;
    @(negedge clk);
    n_total++; if (state_o !== 2'd1) $display("FAIL start_wins_state got=%0d required=1", state_o); else n_pass++;
    n_total++; if (count !== 9'd0) $display("FAIL start_wins_count got=%0d required=0", count); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_checksum;
    int w;
    do_start(8'h00);
    send(3'd1, 4'hE, 4'b0100, 1'b0, 4'd2, 4'd1, 4'd0, 24'd5, w);
    send(3'd2, 4'hE, 4'h0, 1'b0, 4'd4, 4'd3, 4'd0, 24'd8, w);
    send(3'd7, 4'hE, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 24'd0, w);
    idle_cycles(2);
`ifdef INSTR_ENCODER_CHECKSUM_EN
    @(negedge clk);
    n_total++; if (checksum !== (32'hE2812005 ^ 32'hE5934008))
      $display("FAIL checksum_final got=%h required=%h", checksum, 32'hE2812005 ^ 32'hE5934008);
    else n_pass++;
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    test_reset;
    test_dp_imm;
    test_back_to_back;
    test_wrap_full;
    test_errors;
    test_start_inflight;
    test_finish_inflight;
    test_checksum;
    idle_cycles(2);
    n_total++; if (sb.size() != 0) $display("FAIL final_pending got=%0d required=0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
